// File: rtl/sram_arbiter_pkg.sv
// Shared constants, types and sizing helpers for the two-master SRAM arbiter.
package sram_arbiter_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam logic        OWNER_INST    = 1'b0;
    localparam logic        OWNER_DATA    = 1'b1;
    localparam logic [1:0]  STARVE_MAX    = 2'd2;

    typedef enum logic [1:0] {
        GntNone,
        GntInst,
        GntData
    } gnt_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner-bit FIFO: remembers which master owns each accepted, unanswered transaction.
module arb_owner_fifo
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned  DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW    = cnt_width(DEPTH),
    localparam int unsigned PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_owner,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_head,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DEPTH-1:0] r_slots;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slots <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_slots[r_wptr] <= i_owner;
                r_wptr          <= (r_wptr == LAST_C) ? '0 : r_wptr + PW'(1);
            end
            if (i_pop) begin
                r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign o_head  = r_slots[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction and data sram-like masters onto one slave port and routes
// in-order responses back to whichever master issued each transaction.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err_unexp
);

    localparam int unsigned   CW      = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    gnt_e          w_gnt;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_head;
    logic [CW-1:0] w_count;
    logic [1:0]    r_starve;
    logic          r_err;

    // Data wins unless inst has already lost STARVE_MAX times in a row.
    always_comb begin
        w_gnt = GntNone;
        if (inst_req && (!data_req || r_starve == STARVE_MAX)) begin
            w_gnt = GntInst;
        end else if (data_req) begin
            w_gnt = GntData;
        end
    end

    assign mem_req   = (inst_req | data_req) & (w_count < DEPTH_C) & ~reset;
    assign mem_wr    = (w_gnt == GntData) ? data_wr    : inst_wr;
    assign mem_size  = (w_gnt == GntData) ? data_size  : inst_size;
    assign mem_wstrb = (w_gnt == GntData) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (w_gnt == GntData) ? data_addr  : inst_addr;
    assign mem_wdata = (w_gnt == GntData) ? data_wdata : inst_wdata;

    assign w_accept     = mem_req & mem_addr_ok;
    assign inst_addr_ok = w_accept & (w_gnt == GntInst);
    assign data_addr_ok = w_accept & (w_gnt == GntData);

    assign w_push = w_accept & ~w_full;
    assign w_pop  = mem_data_ok & ~w_empty & ~reset;

    assign inst_data_ok = w_pop & (w_head == OWNER_INST);
    assign data_data_ok = w_pop & (w_head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_owner_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_owner((w_gnt == GntData) ? OWNER_DATA : OWNER_INST),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_head (w_head),
        .o_count(w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            if (!inst_req || (w_accept && w_gnt == GntInst)) begin
                r_starve <= '0;
            end else if (w_accept && w_gnt == GntData && r_starve != STARVE_MAX) begin
                r_starve <= r_starve + 2'd1;
            end
            if (mem_data_ok && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_unexp = r_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table plus owner-order scoreboard.
module tb_sram_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err_unexp;

    sram_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_size   (inst_size),
        .inst_wstrb  (inst_wstrb),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .err_unexp   (err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        eia;
        logic        eda;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    logic q_owner[$];
    logic model_err = 1'b0;
    int   cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic apply(input logic ir, input logic dr, input logic aok, input logic dok,
                         input logic [31:0] rd, input logic eia, input logic eda,
                         input string nm);
        logic exp_mreq;
        logic owner;
        cyc++;
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        inst_addr   = 32'h1000_0000 + cyc;
        data_addr   = 32'h2000_0000 + cyc;
        #2;
        exp_mreq = (ir | dr) && (q_owner.size() < DEPTH);
        check({nm, ".mem_req"}, mem_req, exp_mreq);
        check({nm, ".inst_addr_ok"}, inst_addr_ok, eia);
        check({nm, ".data_addr_ok"}, data_addr_ok, eda);
        if (eia || eda) begin
            check({nm, ".mem_addr"}, mem_addr, eda ? data_addr : inst_addr);
            check({nm, ".mem_wr"}, mem_wr, eda ? data_wr : inst_wr);
            check({nm, ".mem_wdata"}, mem_wdata, eda ? data_wdata : inst_wdata);
            check({nm, ".mem_wstrb"}, mem_wstrb, eda ? data_wstrb : inst_wstrb);
            check({nm, ".mem_size"}, mem_size, eda ? data_size : inst_size);
        end
        if (dok && q_owner.size() > 0) begin
            owner = q_owner.pop_front();
            check({nm, ".inst_data_ok"}, inst_data_ok, !owner);
            check({nm, ".data_data_ok"}, data_data_ok, owner);
            if (owner) check({nm, ".data_rdata"}, data_rdata, rd);
            else       check({nm, ".inst_rdata"}, inst_rdata, rd);
        end else begin
            check({nm, ".inst_data_ok"}, inst_data_ok, 1'b0);
            check({nm, ".data_data_ok"}, data_data_ok, 1'b0);
            if (dok) model_err = 1'b1;
        end
        if (eia) q_owner.push_back(1'b0);
        if (eda) q_owner.push_back(1'b1);
        @(posedge clk);
        #1;
        check({nm, ".err_unexp"}, err_unexp, model_err);
    endtask

    vec_t tbl[7];

    initial begin
        // Both masters held high with an in-order slave answering one cycle later.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA4, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA5, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hA6, 1'b0, 1'b0};

        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_wdata = 32'hAAAA_0001;
        data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'h1; data_wdata = 32'hDDDD_0002;
        inst_addr = '0; data_addr = '0; mem_rdata = '0;

        // Outputs stay quiet under reset even with every input asserted.
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        #2;
        check("rst.mem_req", mem_req, 1'b0);
        check("rst.inst_addr_ok", inst_addr_ok, 1'b0);
        check("rst.data_addr_ok", data_addr_ok, 1'b0);
        check("rst.inst_data_ok", inst_data_ok, 1'b0);
        check("rst.data_data_ok", data_data_ok, 1'b0);
        check("rst.err_unexp", err_unexp, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

        // Single instruction fetch.
        apply(1, 0, 1, 0, 32'h0,         1, 0, "fetch.req");
        apply(0, 0, 0, 1, 32'h0200_0513, 0, 0, "fetch.rsp");

        // Starvation guard: grant order D,D,I,D,D,I.
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].ir, tbl[i].dr, tbl[i].aok, tbl[i].dok, tbl[i].rd,
                  tbl[i].eia, tbl[i].eda, $sformatf("starve[%0d]", i));
        end
        check("starve.cnt_max", {30'd0, dut.r_starve} <= 32'd2, 1'b1);

        // Fill to DEPTH, then a pop only reopens the port on the following cycle.
        for (int i = 0; i < 4; i++) apply(1, 0, 1, 0, 32'h0, 1, 0, $sformatf("fill[%0d]", i));
        apply(1, 0, 1, 0, 32'h0,  0, 0, "full.blocked");
        check("full.mem_req_low", mem_req, 1'b0);
        apply(1, 0, 1, 1, 32'h55, 0, 0, "full.pop_same");
        apply(1, 0, 1, 0, 32'h0,  1, 0, "full.reopen");
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 32'h60 + i, 0, 0, $sformatf("drain[%0d]", i));

        // Interleaved owners I,D,D,I answered in order.
        apply(1, 0, 1, 0, 32'h0,  1, 0, "mix.I0");
        apply(0, 1, 1, 0, 32'h0,  0, 1, "mix.D1");
        apply(0, 1, 1, 0, 32'h0,  0, 1, "mix.D2");
        apply(1, 0, 1, 0, 32'h0,  1, 0, "mix.I3");
        apply(0, 0, 0, 1, 32'h11, 0, 0, "mix.r11");
        apply(0, 0, 0, 1, 32'h22, 0, 0, "mix.r22");
        apply(0, 0, 0, 1, 32'h33, 0, 0, "mix.r33");
        apply(0, 0, 0, 1, 32'h44, 0, 0, "mix.r44");

        // Unexpected response with nothing outstanding: flag is set and sticky.
        check("unexp.pre", err_unexp, 1'b0);
        apply(0, 0, 0, 1, 32'hBAD, 0, 0, "unexp.hit");
        apply(0, 0, 0, 0, 32'h0,   0, 0, "unexp.hold0");
        apply(0, 0, 0, 0, 32'h0,   0, 0, "unexp.hold1");

        // Reset with three outstanding discards them all.
        for (int i = 0; i < 3; i++) apply(1, 0, 1, 0, 32'h0, 1, 0, $sformatf("pre_rst[%0d]", i));
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        #2;
        check("mid_rst.count", {{(32-$bits(dut.w_count)){1'b0}}, dut.w_count}, 32'd0);
        check("mid_rst.mem_req", mem_req, 1'b0);
        check("mid_rst.inst_data_ok", inst_data_ok, 1'b0);
        check("mid_rst.data_data_ok", data_data_ok, 1'b0);
        check("mid_rst.err_unexp", err_unexp, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        q_owner.delete();
        model_err = 1'b0;
        apply(0, 0, 0, 1, 32'h77, 0, 0, "post_rst.late");
        check("post_rst.wptr0", {30'd0, dut.u_fifo.r_wptr}, 32'd0);
        apply(0, 1, 1, 0, 32'h0,  0, 1, "post_rst.acc");
        check("post_rst.slot0", dut.u_fifo.r_slots[0], 1'b1);
        check("post_rst.wptr1", {30'd0, dut.u_fifo.r_wptr}, 32'd1);
        apply(0, 0, 0, 1, 32'h88, 0, 0, "post_rst.rsp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
